// File: rtl/rx_data_sampler.sv
// UART receive sampler: oversampled start/data/parity/stop framing with
// 3-sample majority voting per bit.
//
// Ports:
//   CLK           - clock, rising edge
//   RST           - synchronous active-high reset
//   RX_IN         - serial line, synchronized to CLK, idle high
//   prescale      - oversampling ratio P (8/16/32, others act as 16)
//   par_en        - frame carries a parity bit between data and stop
//   parallel_data - received byte, LSB first on the line
//   parity_bit    - sampled parity bit
//   par_check_en  - one-cycle strobe after the parity bit is decided
//   data_valid    - one-cycle strobe for a frame with a good stop bit
//   stop_error    - one-cycle strobe for a frame with a bad stop bit
//   busy          - high while a frame is being received
//
// Optional feature: define RX_START_GLITCH_FILTER_EN to drop frames whose
// start bit votes high at its decision edge.
module rx_data_sampler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] prescale,
  input  logic       par_en,
  output logic [7:0] parallel_data,
  output logic       parity_bit,
  output logic       par_check_en,
  output logic       data_valid,
  output logic       stop_error,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state;
  logic [5:0] edge_cnt;
  logic [2:0] bit_cnt;
  logic [5:0] p_lat;
  logic       pe_lat;
  logic [1:0] smp;
  logic [7:0] shift;

  logic [5:0] p_dec;
  logic [5:0] half;
  logic       at_s0;
  logic       at_s1;
  logic       at_dec;
  logic       at_end;
  logic       maj;
  logic [7:0] shift_nxt;

  // Illegal ratios fall back to 16.
  always_comb begin
    p_dec = 6'd16;
    unique case (1'b1)
      (prescale == 6'd8):  p_dec = 6'd8;
      (prescale == 6'd32): p_dec = 6'd32;
      default:             p_dec = 6'd16;
    endcase
  end

  // Sample points sit around mid-bit of the latched ratio.
  always_comb begin
    half   = p_lat >> 1;
    at_s0  = (edge_cnt == half - 6'd1);
    at_s1  = (edge_cnt == half);
    at_dec = (edge_cnt == half + 6'd1);
    at_end = (edge_cnt == p_lat - 6'd1);
  end

  // Third sample is the live line value at the decision edge.
  always_comb begin
    maj = (smp[0] & smp[1]) |
          (smp[0] & RX_IN)  |
          (smp[1] & RX_IN);
    shift_nxt = {maj, shift[7:1]};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      edge_cnt      <= 6'd0;
      bit_cnt       <= 3'd0;
      p_lat         <= 6'd16;
      pe_lat        <= 1'b0;
      smp           <= 2'b00;
      shift         <= 8'h00;
      parallel_data <= 8'h00;
      parity_bit    <= 1'b0;
      par_check_en  <= 1'b0;
      data_valid    <= 1'b0;
      stop_error    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      par_check_en <= 1'b0;
      data_valid   <= 1'b0;
      stop_error   <= 1'b0;

      if (state == IDLE) begin
        // Config tracks the inputs only while idle, so the
        // value seen on the start cycle holds for the frame.
        p_lat    <= p_dec;
        pe_lat   <= par_en;
        edge_cnt <= 6'd0;
        if (!RX_IN) begin
          state    <= START;
          edge_cnt <= 6'd1;
          bit_cnt  <= 3'd0;
          busy     <= 1'b1;
        end
      end else begin
        edge_cnt <= at_end ? 6'd0 : edge_cnt + 6'd1;
        if (at_s0) smp[0] <= RX_IN;
        if (at_s1) smp[1] <= RX_IN;

        unique case (state)
          START: begin
`ifdef RX_START_GLITCH_FILTER_EN
            if (at_dec && maj) begin
              state    <= IDLE;
              edge_cnt <= 6'd0;
              busy     <= 1'b0;
            end else if (at_end) begin
              state <= DATA;
            end
`else
            if (at_end) state <= DATA;
`endif
          end

          DATA: begin
            if (at_dec) begin
              shift <= shift_nxt;
              if (bit_cnt == 3'd7)
                parallel_data <= shift_nxt;
            end
            if (at_end) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7)
                state <= pe_lat ? PARITY : STOP;
            end
          end

          PARITY: begin
            if (at_dec) begin
              parity_bit   <= maj;
              par_check_en <= 1'b1;
            end
            if (at_end) state <= STOP;
          end

          STOP: begin
            if (at_dec) begin
              data_valid <= maj;
              stop_error <= ~maj;
            end
            if (at_end) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            state    <= IDLE;
            edge_cnt <= 6'd0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_data_sampler.sv
// Bench for rx_data_sampler: frame-level model over a prebuilt line
// waveform, per-cycle compare plus literal checkpoints.
module tb_rx_data_sampler;

  localparam int MAXC = 2048;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       par_en;
  logic [7:0] parallel_data;
  logic       parity_bit;
  logic       par_check_en;
  logic       data_valid;
  logic       stop_error;
  logic       busy;

  rx_data_sampler dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_IN         (RX_IN),
    .prescale      (prescale),
    .par_en        (par_en),
    .parallel_data (parallel_data),
    .parity_bit    (parity_bit),
    .par_check_en  (par_check_en),
    .data_valid    (data_valid),
    .stop_error    (stop_error),
    .busy          (busy)
  );

  always #5 CLK = ~CLK;

  logic       rx_w  [MAXC];
  logic       rst_w [MAXC];
  logic [5:0] pre_w [MAXC];
  logic       pe_w  [MAXC];

  logic       e_chk  [MAXC];
  logic       e_busy [MAXC];
  logic       e_dv   [MAXC];
  logic       e_se   [MAXC];
  logic       e_pce  [MAXC];
  logic       e_pb   [MAXC];
  logic [7:0] e_pd   [MAXC];

  logic [7:0] m_pd;
  logic       m_pb;
  logic       m_known;

  int wp;
  int n_chk;
  int n_fail;

  typedef struct {
    int c;
    int s;
    int v;
  } lit_t;
  lit_t lits[$];

  function automatic int pdec(input logic [5:0] pv);
    if (pv == 6'd8)  return 8;
    if (pv == 6'd32) return 32;
    return 16;
  endfunction

  task automatic put(input logic rx, input logic rs,
                     input logic [5:0] pv, input logic pe);
    rx_w[wp]  = rx;
    rst_w[wp] = rs;
    pre_w[wp] = pv;
    pe_w[wp]  = pe;
    wp++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b1, 1'b0, 6'd32, 1'b1);
  endtask

  task automatic reset_n(input int n);
    for (int i = 0; i < n; i++) put(1'b1, 1'b1, 6'd8, 1'b0);
  endtask

  // Config is valid only on the start cycle; every other frame
  // cycle carries a conflicting value.
  task automatic frame(input logic [5:0] pv, input logic pe,
                       input logic [7:0] d, input logic pb,
                       input logic sb, output int s);
    int p;
    logic [5:0] g;
    p = pdec(pv);
    g = (pv == 6'd8) ? 6'd32 : 6'd8;
    s = wp;
    for (int i = 0; i < p; i++)
      put(1'b0, 1'b0, (i == 0) ? pv : g, (i == 0) ? pe : ~pe);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < p; i++) put(d[k], 1'b0, g, ~pe);
    if (pe)
      for (int i = 0; i < p; i++) put(pb, 1'b0, g, ~pe);
    for (int i = 0; i < p; i++) put(sb, 1'b0, g, ~pe);
  endtask

  task automatic lit(input int c, input int s, input int v);
    lit_t l;
    l.c = c;
    l.s = s;
    l.v = v;
    lits.push_back(l);
  endtask

  // Majority of the three mid-bit line samples of bit bi.
  function automatic logic vote(input int s, input int bi,
                                input int p);
    int c0;
    int n;
    c0 = s + bi * p + p / 2 - 1;
    if (c0 + 2 >= MAXC) return 1'b1;
    n = int'(rx_w[c0]) + int'(rx_w[c0 + 1]) + int'(rx_w[c0 + 2]);
    return (n >= 2);
  endfunction

  task automatic setc(input int c, input logic b, input logic dv,
                      input logic se, input logic pce);
    if (c < MAXC) begin
      e_chk[c]  = m_known;
      e_busy[c] = b;
      e_dv[c]   = dv;
      e_se[c]   = se;
      e_pce[c]  = pce;
      e_pd[c]   = m_pd;
      e_pb[c]   = m_pb;
    end
  endtask

  // Walks the waveform one frame at a time; outputs for cycle
  // c+1 follow from what the line and reset did in cycle c.
  task automatic run_model();
    int t, s, p, stopi, endl, dk, c;
    logic pe, ab, dv, se, pce;
    logic [7:0] d;
    m_pd = 8'h00;
    m_pb = 1'b0;
    m_known = 1'b0;
    t = 0;
    while (t < MAXC - 1) begin
      if (rst_w[t]) begin
        m_pd = 8'h00;
        m_pb = 1'b0;
        m_known = 1'b1;
        setc(t + 1, 0, 0, 0, 0);
        t++;
      end else if (rx_w[t]) begin
        setc(t + 1, 0, 0, 0, 0);
        t++;
      end else begin
        s = t;
        p = pdec(pre_w[s]);
        pe = pe_w[s];
        stopi = pe ? 10 : 9;
        endl = (stopi + 1) * p;
        dk = p / 2 + 1;
`ifdef RX_START_GLITCH_FILTER_EN
        if (vote(s, 0, p)) endl = dk + 1;
`endif
        for (int i = 0; i < 8; i++) d[i] = vote(s, 1 + i, p);
        ab = 1'b0;
        for (int k = 0; k < endl; k++) begin
          c = s + k;
          if (c + 1 >= MAXC) break;
          if (rst_w[c]) begin
            m_pd = 8'h00;
            m_pb = 1'b0;
            setc(c + 1, 0, 0, 0, 0);
            t = c + 1;
            ab = 1'b1;
            break;
          end
          dv = 0;
          se = 0;
          pce = 0;
          if (k == 8 * p + dk) m_pd = d;
          if (pe && k == 9 * p + dk) begin
            m_pb = vote(s, 9, p);
            pce = 1;
          end
          if (k == stopi * p + dk) begin
            dv = vote(s, stopi, p);
            se = ~dv;
          end
          setc(c + 1, (k + 1 < endl), dv, se, pce);
        end
        if (!ab) t = s + endl;
      end
    end
  endtask

  task automatic chk(input string nm, input int c,
                     input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %02h, want %02h",
               nm, c, act, exp);
    end
  endtask

  function automatic logic [7:0] sel(input int s);
    case (s)
      0:       return parallel_data;
      1:       return {7'd0, parity_bit};
      2:       return {7'd0, par_check_en};
      3:       return {7'd0, data_valid};
      4:       return {7'd0, stop_error};
      default: return {7'd0, busy};
    endcase
  endfunction

  int s1, s2, s3, s4, s5, s6, s7, s8, s9, sx;

  initial begin
    n_chk = 0;
    n_fail = 0;
    wp = 0;
    for (int i = 0; i < MAXC; i++) begin
      rx_w[i] = 1'b1;
      rst_w[i] = 1'b0;
      pre_w[i] = 6'd16;
      pe_w[i] = 1'b0;
      e_chk[i] = 1'b0;
      e_busy[i] = 1'b0;
      e_dv[i] = 1'b0;
      e_se[i] = 1'b0;
      e_pce[i] = 1'b0;
      e_pb[i] = 1'b0;
      e_pd[i] = 8'h00;
    end

    reset_n(3);
    idle(4);
    frame(6'd8, 1'b1, 8'hA5, 1'b0, 1'b1, s1);
    lit(s1 + 2, 5, 1);
    lit(s1 + 78, 2, 1);
    lit(s1 + 78, 1, 0);
    lit(s1 + 85, 3, 0);
    lit(s1 + 86, 3, 1);
    lit(s1 + 86, 0, 8'hA5);

    idle(5);
    frame(6'd16, 1'b0, 8'h3C, 1'b0, 1'b1, s2);
    rx_w[s2 + 3 * 16 + 8] = ~rx_w[s2 + 3 * 16 + 8];
    rx_w[s2 + 5 * 16] = ~rx_w[s2 + 5 * 16];
    lit(s2 + 154, 3, 1);
    lit(s2 + 154, 0, 8'h3C);

    idle(5);
    frame(6'd8, 1'b0, 8'h00, 1'b0, 1'b0, s3);
    lit(s3 + 78, 4, 1);
    lit(s3 + 78, 3, 0);

    idle(5);
    s4 = wp;
    put(1'b0, 1'b0, 6'd8, 1'b0);
    put(1'b0, 1'b0, 6'd32, 1'b1);
    for (int i = 0; i < 90; i++) put(1'b1, 1'b0, 6'd32, 1'b1);
`ifdef RX_START_GLITCH_FILTER_EN
    lit(s4 + 5, 5, 1);
    lit(s4 + 6, 5, 0);
`else
    lit(s4 + 78, 3, 1);
    lit(s4 + 78, 0, 8'hFF);
`endif

    idle(5);
    frame(6'd8, 1'b0, 8'hA5, 1'b0, 1'b1, s5);
    wp = s5 + 41;
    rst_w[s5 + 40] = 1'b1;
    lit(s5 + 41, 5, 0);
    lit(s5 + 41, 0, 8'h00);
    idle(5);
    frame(6'd8, 1'b1, 8'h5A, 1'b0, 1'b1, s6);
    lit(s6 + 86, 3, 1);
    lit(s6 + 86, 0, 8'h5A);

    idle(5);
    frame(6'd8, 1'b0, 8'h01, 1'b0, 1'b1, s7);
    frame(6'd8, 1'b0, 8'h80, 1'b0, 1'b1, sx);
    lit(s7 + 78, 3, 1);
    lit(s7 + 78, 0, 8'h01);
    lit(s7 + 80, 5, 0);
    lit(s7 + 158, 3, 1);
    lit(s7 + 158, 0, 8'h80);

    idle(5);
    frame(6'd32, 1'b1, 8'h96, 1'b0, 1'b1, s8);
    lit(s8 + 338, 3, 1);
    lit(s8 + 338, 0, 8'h96);

    idle(5);
    frame(6'd10, 1'b1, 8'hC3, 1'b1, 1'b1, s9);
    lit(s9 + 154, 2, 1);
    lit(s9 + 154, 1, 1);
    idle(10);

    run_model();

    RST = 1'b1;
    RX_IN = 1'b1;
    prescale = 6'd8;
    par_en = 1'b0;
    @(posedge CLK);
    #1;
    for (int c = 0; c < wp && c < MAXC - 1; c++) begin
      RX_IN = rx_w[c];
      RST = rst_w[c];
      prescale = pre_w[c];
      par_en = pe_w[c];
      @(negedge CLK);
      if (e_chk[c]) begin
        chk("busy", c, sel(5), {7'd0, e_busy[c]});
        chk("data_valid", c, sel(3), {7'd0, e_dv[c]});
        chk("stop_error", c, sel(4), {7'd0, e_se[c]});
        chk("par_check_en", c, sel(2), {7'd0, e_pce[c]});
        chk("parity_bit", c, sel(1), {7'd0, e_pb[c]});
        chk("parallel_data", c, sel(0), e_pd[c]);
      end
      foreach (lits[i])
        if (lits[i].c == c)
          chk("literal", c, sel(lits[i].s), 8'(lits[i].v));
      @(posedge CLK);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_data_sampler.md
RX_DATA_SAMPLER -- requirements
Module: rx_data_sampler

Interface
REQ-001 The block SHALL expose `CLK`, input, 1 bit, the single clock, rising edge.
REQ-002 The block SHALL expose `RST`, input, 1 bit, a synchronous active-high reset.
REQ-003 The block SHALL expose `RX_IN`, input, 1 bit, serial line, already synchronized to `CLK`, idle high.
REQ-004 The block SHALL expose `prescale`, input, 6 bits, oversampling ratio P; legal values 8/16/32, any other value treated as 16.
REQ-005 The block SHALL expose `par_en`, input, 1 bit; 1 = the frame carries a parity bit between data and stop.
REQ-006 The block SHALL expose `parallel_data`, output, 8 bits, the received data byte, LSB received first.
REQ-007 The block SHALL expose `parity_bit`, output, 1 bit, the sampled parity bit.
REQ-008 The block SHALL expose `par_check_en`, output, 1 bit, a one-cycle strobe to the downstream parity checker.
REQ-009 The block SHALL expose `data_valid`, output, 1 bit, a one-cycle strobe for a good frame.
REQ-010 The block SHALL expose `stop_error`, output, 1 bit, a one-cycle strobe for a bad stop bit.
REQ-011 The block SHALL expose `busy`, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, each bit period lasting P cycles, counted by `edge_cnt` from 0 to P-1.
REQ-013 In IDLE with `RX_IN`=0, that cycle SHALL be edge 0 of the start bit; the next cycle enters START with `edge_cnt`=1, and that clock edge is cycle 1 of the frame.
REQ-014 Each bit SHALL be sampled at edges P/2-1, P/2 and P/2+1, and the bit value SHALL be the majority of the 3 samples, decided at edge P/2+1.
REQ-015 At edge P-1 of each bit, `edge_cnt` SHALL wrap to 0 and the FSM SHALL advance: START to DATA, DATA to DATA until 8 bits are taken, then to PARITY if `par_en`=1 else to STOP, and PARITY to STOP.
REQ-016 Each DATA bit SHALL be shifted in from the MSB side so that bit 0 is received first, using a 3-bit bit counter from 0 to 7.
REQ-017 `parallel_data` SHALL update only when the 8th data bit is decided, and SHALL hold otherwise.
REQ-018 On the PARITY decision, `parity_bit` SHALL be registered, and `par_check_en` SHALL be high for exactly the following cycle.
REQ-019 One cycle after the STOP decision, `data_valid`=1 if the stop bit is 1, else `stop_error`=1, each for exactly 1 cycle and never both.
REQ-020 After STOP edge P-1, the FSM SHALL go to IDLE; a start bit detected in the very next cycle SHALL begin a new frame with no dead cycle.
REQ-021 `par_en` and `prescale` SHALL be sampled only in IDLE and held for the frame; changes mid-frame SHALL have no effect.
REQ-022 `RX_IN` low in STOP at edge 0 SHALL NOT restart the frame; start detection SHALL occur only in IDLE.

Reset
REQ-023 With `RST`=1 at a clock edge, the block SHALL enter IDLE with `edge_cnt` and the bit counter cleared.
REQ-024 With `RST`=1 at a clock edge, `parallel_data`=0x00, `parity_bit`=0, and all strobes and `busy` SHALL be 0.
REQ-025 A reset mid-frame SHALL abort the frame with no strobe, and a frame in flight SHALL NOT complete after `RST` falls.

Configuration
REQ-026 Macro `RX_START_GLITCH_FILTER_EN`, when defined, SHALL check the START majority at edge P/2+1; if it is 1, the FSM SHALL return to IDLE the next cycle with no strobe.
REQ-027 When `RX_START_GLITCH_FILTER_EN` is undefined, the START sample SHALL be ignored and the frame always proceeds to DATA.

Verification
REQ-028 With P=8, `par_en`=1, frame 0xA5, parity 0, stop 1 (cycle 0 = first low `RX_IN` in IDLE), the bench SHALL see `parallel_data`=0xA5; `parity_bit`=0 and a `par_check_en` pulse at cycle 78; a `data_valid` pulse at cycle 86.
REQ-029 With P=16, `par_en`=0, frame 0x3C, stop 1, the bench SHALL see no `par_check_en`; `data_valid` at cycle 154 with `parallel_data`=0x3C.
REQ-030 With P=8, `par_en`=0, frame 0x00, stop 0, the bench SHALL see a `stop_error` pulse at cycle 78 and no `data_valid`.
REQ-031 With P=8 and `RX_IN` low for cycles 0-1 then high: with the macro, `busy` SHALL fall at cycle 6 and no strobe occurs; without the macro, `data_valid` SHALL pulse at cycle 78 with 0xFF.
REQ-032 With P=8, 0xA5, `RST` asserted at cycle 40, then a fresh frame of 0x5A, the bench SHALL see no strobe for the aborted frame; the new frame yields 0x5A.
REQ-033 With P=8, back-to-back frames 0x01 then 0x80, the second start bit low at cycle 80, the bench SHALL see `data_valid` pulses at cycles 78 and 158 with 0x01 then 0x80.
